// File: rtl/acorn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acorn_pkg
// Brief   : ACORN-128 constants, FSM encodings and single-step functions.
// Revision: 1.0 - initial release
// ============================================================================
package acorn_pkg;

    localparam int ACORN_SW    = 293;
    localparam int PAD_BITS    = 256;
    localparam int PAD_CA_BITS = 128;

    typedef logic [ACORN_SW-1:0] acorn_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // The six LFSR taps are folded in top-down so each uses the old lower bit.
    function automatic acorn_state_t lfsr128(input acorn_state_t s);
        acorn_state_t t;
        t      = s;
        t[289] = t[289] ^ t[235] ^ t[230];
        t[230] = t[230] ^ t[196] ^ t[193];
        t[193] = t[193] ^ t[160] ^ t[154];
        t[154] = t[154] ^ t[111] ^ t[107];
        t[107] = t[107] ^ t[66]  ^ t[61];
        t[61]  = t[61]  ^ t[23]  ^ t[0];
        return t;
    endfunction

    function automatic logic ksg128(input acorn_state_t s);
        acorn_state_t t;
        t = lfsr128(s);
        return t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    endfunction

    function automatic acorn_state_t state_update128(input acorn_state_t s, input logic m,
                                                     input logic ca, input logic cb);
        acorn_state_t t;
        logic         ks;
        logic         f;
        t  = lfsr128(s);
        ks = ksg128(s);
        f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
        return {f ^ m, t[ACORN_SW-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acorn_step_dw.sv
`default_nettype none
// ============================================================================
// Module  : acorn_step_dw
// Brief   : DW chained ACORN-128 steps in one combinational cone.
// Revision: 1.0 - initial release
// ============================================================================
module acorn_step_dw
    import acorn_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [ACORN_SW-1:0] i_state,
    input  logic [DW-1:0]       i_m,
    input  logic [DW-1:0]       i_ca,
    input  logic                i_cb,
    input  logic                i_decrypt,
    output logic [ACORN_SW-1:0] o_state,
    output logic [DW-1:0]       o_x
);

    acorn_state_t w_s;
    logic         w_ks;
    logic         w_m;

    // Decrypt feeds the recovered plaintext bit back into the state.
    always_comb begin
        w_s  = i_state;
        o_x  = '0;
        w_ks = 1'b0;
        w_m  = 1'b0;
        for (int j = 0; j < DW; j++) begin
            w_ks   = ksg128(w_s);
            o_x[j] = i_m[j] ^ w_ks;
            w_m    = i_decrypt ? o_x[j] : i_m[j];
            w_s    = state_update128(w_s, w_m, i_ca[j], i_cb);
        end
        o_state = w_s;
    end

endmodule
`default_nettype wire

// File: rtl/acorn_crypt_stream.sv
`default_nettype none
// ============================================================================
// Module  : acorn_crypt_stream
// Brief   : ACORN-128 message-phase encrypt/decrypt with internal padding.
// Revision: 1.0 - initial release
// ============================================================================
module acorn_crypt_stream
    import acorn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [LEN_W-1:0]    len_beats,
    input  logic [ACORN_SW-1:0] state_in,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [ACORN_SW-1:0] state_out
);

    localparam int         PAD_CYCLES = PAD_BITS / DW;
    localparam logic [8:0] PAD_LAST   = 9'(PAD_CYCLES - 1);

    logic [1:0]       fsm_q, fsm_d;
    acorn_state_t     acorn_q, acorn_d;
    acorn_state_t     state_out_q, state_out_d;
    logic             dec_q, dec_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [8:0]       pad_cnt_q, pad_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;

    logic [DW-1:0]    step_m;
    logic [DW-1:0]    step_ca;
    logic [DW-1:0]    step_x;
    logic             step_dec;
    acorn_state_t     step_state;
    logic             accept;

    assign in_ready  = (fsm_q == ST_DATA) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (fsm_q != ST_IDLE);
    assign done      = (fsm_q == ST_FIN);
    assign state_out = state_out_q;

    // Padding: a single 1 at pad bit 0, ca high for the first 128 pad bits.
    always_comb begin
        step_m   = in_data;
        step_ca  = '1;
        step_dec = dec_q;
        if (fsm_q == ST_PAD) begin
            step_dec = 1'b0;
            for (int j = 0; j < DW; j++) begin
                step_m[j]  = (pad_cnt_q == 9'd0) && (j == 0);
                step_ca[j] = ((int'(pad_cnt_q) * DW) + j) < PAD_CA_BITS;
            end
        end
    end

    acorn_step_dw #(
        .DW        (DW)
    ) u_step (
        .i_state   (acorn_q),
        .i_m       (step_m),
        .i_ca      (step_ca),
        .i_cb      (1'b0),
        .i_decrypt (step_dec),
        .o_state   (step_state),
        .o_x       (step_x)
    );

    always_comb begin
        fsm_d       = fsm_q;
        acorn_d     = acorn_q;
        state_out_d = state_out_q;
        dec_d       = dec_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        pad_cnt_d   = pad_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (accept) begin
            out_data_d  = step_x;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    acorn_d   = state_in;
                    dec_d     = decrypt;
                    len_d     = len_beats;
                    cnt_d     = '0;
                    pad_cnt_d = '0;
                    fsm_d     = (len_beats == '0) ? ST_PAD : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    acorn_d = step_state;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        fsm_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                acorn_d   = step_state;
                pad_cnt_d = pad_cnt_q + 9'd1;
                if (pad_cnt_q == PAD_LAST) begin
                    fsm_d       = ST_FIN;
                    state_out_d = step_state;
                end
            end
            ST_FIN: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            acorn_q     <= '0;
            state_out_q <= '0;
            dec_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            pad_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            acorn_q     <= acorn_d;
            state_out_q <= state_out_d;
            dec_q       <= dec_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acorn_crypt_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_acorn_crypt_stream
// Brief   : Self-checking bench for acorn_crypt_stream against a bit-serial model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acorn_crypt_stream;

    localparam int SW = 293;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic            start, decrypt, in_valid, out_ready;
    logic [LW-1:0]   len_beats;
    logic [SW-1:0]   state_in;
    logic [7:0]      in_data;
    logic            in_ready, out_valid, busy, done;
    logic [7:0]      out_data;
    logic [SW-1:0]   state_out;

    logic            a_start, a_in_valid, a_in_data, a_in_ready, a_out_valid, a_out_data;
    logic            a_out_ready, a_busy, a_done;
    logic [LW-1:0]   a_len;
    logic [SW-1:0]   a_state_out;

    logic            b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
    logic [31:0]     b_in_data, b_out_data;
    logic [LW-1:0]   b_len;
    logic [SW-1:0]   b_state_out;

    acorn_crypt_stream #(.DW(8), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .len_beats(len_beats),
        .state_in(state_in), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
        .done(done), .state_out(state_out)
    );

    acorn_crypt_stream #(.DW(1), .LEN_W(LW)) dut_w1 (
        .clk(clk), .rst(rst), .start(a_start), .decrypt(decrypt), .len_beats(a_len),
        .state_in(state_in), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .busy(a_busy),
        .done(a_done), .state_out(a_state_out)
    );

    acorn_crypt_stream #(.DW(32), .LEN_W(LW)) dut_w32 (
        .clk(clk), .rst(rst), .start(b_start), .decrypt(decrypt), .len_beats(b_len),
        .state_in(state_in), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .busy(b_busy),
        .done(b_done), .state_out(b_state_out)
    );

    // Bit-serial reference: message bits, then 256 pad bits, one step each.
    task automatic model_run(input logic [SW-1:0] s0, input logic [127:0] msg, input int nbits,
                             input logic dec, output logic [127:0] dout, output logic [SW-1:0] fin);
        logic [SW-1:0] s;
        logic ks, f, m, o, din, ca;
        s    = s0;
        dout = '0;
        for (int i = 0; i < nbits + 256; i++) begin
            if (i < nbits) begin
                din = msg[i & 127];
                ca  = 1'b1;
            end else begin
                din = (i == nbits);
                ca  = ((i - nbits) < 128);
            end
            s[289] = s[289] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66]  ^ s[61];
            s[61]  = s[61]  ^ s[23]  ^ s[0];
            ks = s[12] ^ s[154] ^ ((s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]))
                 ^ (s[230] ? s[111] : s[66]);
            f  = s[0] ^ ~s[107] ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]))
                 ^ (ca & s[196]);
            o  = din ^ ks;
            if (i < nbits) dout[i & 127] = o;
            m  = (dec && i < nbits) ? o : din;
            s  = {f ^ m, s[SW-1:1]};
        end
        fin = s;
    endtask

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[SW-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [127:0] rand_msg();
        return {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    logic [127:0]  r_out;
    logic [SW-1:0] r_fin;
    int            r_nout, r_done_cyc;
    bit            r_timeout, r_rdy_seen, r_rdy_in_stall, r_chg_in_stall, r_busy_after, r_done_after;

    // Drives one DW=8 message; mode 0 full rate, 1 five-cycle stall at stall_at, 2 random.
    task automatic run_main(input logic [SW-1:0] s0, input logic [127:0] msg, input int nbeats,
                            input logic dec, input int mode, input int stall_at, input int restart_at);
        int   beat, cyc;
        bit   done_seen, stalling;
        logic [7:0] last_od;
        r_out = '0; r_fin = '0; r_nout = 0; r_done_cyc = -1;
        r_rdy_seen = 0; r_rdy_in_stall = 0; r_chg_in_stall = 0;
        beat = 0; cyc = 0; done_seen = 0; last_od = '0;
        @(negedge clk);
        state_in = s0; decrypt = dec; len_beats = LW'(nbeats); start = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        while (!(done_seen && r_nout >= nbeats) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (start) begin
                state_in = ~s0; len_beats = LW'(3); decrypt = ~dec;
            end else begin
                state_in = s0; len_beats = LW'(nbeats); decrypt = dec;
            end
            in_valid  = (beat < nbeats) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_data   = msg[(beat & 15) * 8 +: 8];
            stalling  = (mode == 1) && (cyc >= stall_at) && (cyc < stall_at + 5);
            out_ready = stalling ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready) r_rdy_seen = 1;
            if (stalling) begin
                if (in_ready) r_rdy_in_stall = 1;
                if (cyc > stall_at && out_data !== last_od) r_chg_in_stall = 1;
            end
            last_od = out_data;
            if (out_valid && out_ready) begin
                r_out[(r_nout & 15) * 8 +: 8] = out_data;
                r_nout++;
            end
            if (in_valid && in_ready) beat++;
            if (done) begin
                done_seen  = 1;
                r_done_cyc = cyc;
                r_fin      = state_out;
            end
        end
        r_timeout = !(done_seen && r_nout >= nbeats);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        r_busy_after = busy;
        r_done_after = done;
    endtask

    logic [SW-1:0] enc_s0, enc_fin;
    logic [127:0]  enc_pt, enc_ct;

    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (state_out !== '0)   begin n_fail++; $display("FAIL reset_state_out got %h exp 0", state_out); end
    endtask

    task automatic test_encrypt();
        for (int i = 0; i < 16; i++) enc_pt[i*8 +: 8] = 8'(i);
        enc_s0 = rand_state();
        model_run(enc_s0, enc_pt, 128, 1'b0, enc_ct, enc_fin);
        run_main(enc_s0, enc_pt, 16, 1'b0, 0, 0, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL enc_timeout got %0d beats exp 16", r_nout); end
        n_checks++; if (r_out !== enc_ct) begin n_fail++; $display("FAIL enc_ciphertext got %h exp %h", r_out, enc_ct); end
        n_checks++; if (r_done_cyc !== 49) begin n_fail++; $display("FAIL enc_done_cycle got %0d exp 49", r_done_cyc); end
        n_checks++; if (r_fin !== enc_fin) begin n_fail++; $display("FAIL enc_state_out got %h exp %h", r_fin, enc_fin); end
        n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL enc_busy_after got %b exp 0", r_busy_after); end
        n_checks++; if (r_done_after !== 1'b0) begin n_fail++; $display("FAIL enc_done_pulse got %b exp 0", r_done_after); end
    endtask

    task automatic test_decrypt();
        run_main(enc_s0, enc_ct, 16, 1'b1, 0, 0, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL dec_timeout got %0d beats exp 16", r_nout); end
        n_checks++; if (r_out !== enc_pt) begin n_fail++; $display("FAIL dec_plaintext got %h exp %h", r_out, enc_pt); end
        n_checks++; if (r_fin !== enc_fin) begin n_fail++; $display("FAIL dec_state_out got %h exp %h", r_fin, enc_fin); end
    endtask

    task automatic test_zero_len();
        logic [SW-1:0] s0, fin;
        logic [127:0]  unused_o;
        s0 = rand_state();
        model_run(s0, '0, 0, 1'b0, unused_o, fin);
        run_main(s0, '0, 0, 1'b0, 0, 0, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got %0d exp done", r_done_cyc); end
        n_checks++; if (r_rdy_seen !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got %b exp 0", r_rdy_seen); end
        n_checks++; if (r_done_cyc !== 33) begin n_fail++; $display("FAIL zero_done_cycle got %0d exp 33", r_done_cyc); end
        n_checks++; if (r_fin !== fin) begin n_fail++; $display("FAIL zero_state_out got %h exp %h", r_fin, fin); end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s0, fin;
        logic [127:0]  msg, ct;
        s0  = rand_state();
        msg = rand_msg();
        model_run(s0, msg, 128, 1'b0, ct, fin);
        run_main(s0, msg, 16, 1'b0, 1, 8, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %0d beats exp 16", r_nout); end
        n_checks++; if (r_rdy_in_stall !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b exp 0", r_rdy_in_stall); end
        n_checks++; if (r_chg_in_stall !== 1'b0) begin n_fail++; $display("FAIL stall_out_data_changed got %b exp 0", r_chg_in_stall); end
        n_checks++; if (r_out !== ct) begin n_fail++; $display("FAIL stall_ciphertext got %h exp %h", r_out, ct); end
        n_checks++; if (r_fin !== fin) begin n_fail++; $display("FAIL stall_state_out got %h exp %h", r_fin, fin); end
        msg = rand_msg();
        model_run(s0, msg, 128, 1'b1, ct, fin);
        run_main(s0, msg, 16, 1'b1, 2, 0, -1);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL rand_timeout got %0d beats exp 16", r_nout); end
        n_checks++; if (r_out !== ct) begin n_fail++; $display("FAIL rand_output got %h exp %h", r_out, ct); end
        n_checks++; if (r_fin !== fin) begin n_fail++; $display("FAIL rand_state_out got %h exp %h", r_fin, fin); end
    endtask

    task automatic test_width_equiv();
        logic [SW-1:0] s0, exp_f, fin1, fin32;
        logic [127:0]  msg, exp_o, got1, got32;
        bit            to1, to32;
        s0  = rand_state();
        msg = rand_msg();
        got1 = '0; got32 = '0; fin1 = '0; fin32 = '0; to1 = 1; to32 = 1;
        model_run(s0, msg, 128, 1'b0, exp_o, exp_f);
        @(negedge clk);
        state_in = s0; decrypt = 1'b0;
        a_len = LW'(128); b_len = LW'(4); a_start = 1'b1; b_start = 1'b1;
        fork
            begin
                int beat, n, c;
                bit d;
                beat = 0; n = 0; c = 0; d = 0;
                while (!(d && n >= 128) && c < 2000) begin
                    @(negedge clk);
                    c++;
                    a_start     = 1'b0;
                    a_in_valid  = (beat < 128);
                    a_in_data   = msg[beat & 127];
                    a_out_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (a_out_valid && a_out_ready) begin got1[n & 127] = a_out_data; n++; end
                    if (a_in_valid && a_in_ready) beat++;
                    if (a_done) begin d = 1; fin1 = a_state_out; end
                end
                to1 = !(d && n >= 128);
                a_in_valid = 1'b0;
            end
            begin
                int beat, n, c;
                bit d;
                beat = 0; n = 0; c = 0; d = 0;
                while (!(d && n >= 4) && c < 2000) begin
                    @(negedge clk);
                    c++;
                    b_start     = 1'b0;
                    b_in_valid  = (beat < 4);
                    b_in_data   = msg[(beat & 3) * 32 +: 32];
                    b_out_ready = 1'b1;
                    #1;
                    if (b_out_valid && b_out_ready) begin got32[(n & 3) * 32 +: 32] = b_out_data; n++; end
                    if (b_in_valid && b_in_ready) beat++;
                    if (b_done) begin d = 1; fin32 = b_state_out; end
                end
                to32 = !(d && n >= 4);
                b_in_valid = 1'b0;
            end
        join
        n_checks++; if (to1 !== 1'b0)    begin n_fail++; $display("FAIL w1_timeout got %b exp 0", to1); end
        n_checks++; if (to32 !== 1'b0)   begin n_fail++; $display("FAIL w32_timeout got %b exp 0", to32); end
        n_checks++; if (got1 !== exp_o)  begin n_fail++; $display("FAIL w1_ciphertext got %h exp %h", got1, exp_o); end
        n_checks++; if (got32 !== exp_o) begin n_fail++; $display("FAIL w32_ciphertext got %h exp %h", got32, exp_o); end
        n_checks++; if (fin1 !== exp_f)  begin n_fail++; $display("FAIL w1_state_out got %h exp %h", fin1, exp_f); end
        n_checks++; if (fin32 !== exp_f) begin n_fail++; $display("FAIL w32_state_out got %h exp %h", fin32, exp_f); end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] s0, fin;
        logic [127:0]  msg, ct;
        int beat;
        s0  = rand_state();
        msg = rand_msg();
        beat = 0;
        @(negedge clk);
        state_in = s0; decrypt = 1'b0; len_beats = LW'(16); start = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = msg[(beat & 15) * 8 +: 8];
            #1;
            if (in_valid && in_ready) beat++;
            if (beat == 7) break;
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (beat !== 7)          begin n_fail++; $display("FAIL rmid_beats got %0d exp 7", beat); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
        n_checks++; if (state_out !== '0)    begin n_fail++; $display("FAIL rmid_state_out got %h exp 0", state_out); end
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rmid_in_ready got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_run(s0, msg, 128, 1'b0, ct, fin);
        run_main(s0, msg, 16, 1'b0, 0, 0, 5);
        n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL restart_timeout got %0d beats exp 16", r_nout); end
        n_checks++; if (r_out !== ct)        begin n_fail++; $display("FAIL restart_ciphertext got %h exp %h", r_out, ct); end
        n_checks++; if (r_fin !== fin)       begin n_fail++; $display("FAIL restart_state_out got %h exp %h", r_fin, fin); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; decrypt = 1'b0; len_beats = '0; state_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        a_start = 1'b0; a_len = '0; a_in_valid = 1'b0; a_in_data = 1'b0; a_out_ready = 1'b0;
        b_start = 1'b0; b_len = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_zero_len();
        test_backpressure();
        test_width_equiv();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acorn_crypt_stream.md
Name: acorn_crypt_stream

Overview:
- Parametrised ACORN-128 encrypt/decrypt engine for the message phase. It follows key/IV initialisation and associated-data absorption, and precedes tag generation.
- Message bits stream through a valid/ready beat interface, DW bits per beat. DW state-update steps run per clock.
- Mode is selectable per message: encrypt or decrypt.
- After the last beat, the block applies the 256-step message padding internally and presents the final 293-bit state to the tag stage.

Parameters:
- DW, 8, bits per beat and state-update steps per clock. Legal values: 1, 2, 4, 8, 16, 32, 64, 128 (must divide 128).
- LEN_W, 16, width of the message-length field, counted in beats.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a message; sampled only in IDLE
- decrypt  in  1  mode, latched at start: 0 = encrypt, 1 = decrypt
- len_beats  in  LEN_W  message length in beats, latched at start; 0 is legal
- state_in  in  293  ACORN state after AD phase, latched at start
- in_valid  in  1  input beat valid
- in_data  in  DW  plaintext (encrypt) or ciphertext (decrypt); bit 0 is processed first
- in_ready  out  1  input beat accepted when in_valid & in_ready
- out_valid  out  1  output beat valid
- out_data  out  DW  ciphertext (encrypt) or plaintext (decrypt)
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in all states except IDLE
- done  out  1  one-cycle pulse when state_out is final
- state_out  out  293  final state after padding; holds until next start

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, state_out=0, FSM=IDLE, counters=0.
- FSM states: IDLE, DATA, PAD, FIN.
  - IDLE -> DATA on start when len_beats>0.
  - IDLE -> PAD on start when len_beats==0.
  - DATA -> PAD once the last beat is accepted.
  - PAD -> FIN after 256/DW cycles.
  - FIN -> IDLE after one cycle; done=1 and state_out is valid during FIN.
- start while busy: ignored.
- Per bit j of a beat, in order: ks = KSG128(S); S = StateUpdate128(S, m, ca=1, cb=0).
  - Encrypt: m = in_data[j], out_data[j] = m ^ ks.
  - Decrypt: out_data[j] = in_data[j] ^ ks, m = out_data[j].
  - The DW steps are chained combinationally within one clock.
- in_ready = (FSM==DATA) & (~out_valid | out_ready).
- Accepted beat: the state register, out_data and out_valid=1 update on the same edge, giving one-cycle latency.
- out_valid clears on out_ready when no new beat is accepted.
- out_data is stable while out_valid & ~out_ready.
- PAD: pad-bit index p runs 0..255, DW per cycle.
  - m = 1 for p==0, else m = 0.
  - ca = 1 for p<128, ca = 0 for p>=128; cb = 0 throughout.
  - Keystream is discarded.
- PAD is entered only after the last output beat is handed off (out_valid may stay high into PAD until accepted). state_out does not depend on output back-pressure timing.
- Beat counter is LEN_W bits and compares against the latched len_beats. No wrap: maximum length is 2^LEN_W-1 beats.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values; the partial message is lost.
- Simultaneous out_ready and new-beat acceptance: the new beat replaces the old, and out_valid stays 1.

Decomposition:
- Package acorn_pkg:
  - ACORN_SW=293
  - PAD_BITS=256
  - PAD_CA_BITS=128
  - functions ksg128(state) and state_update128(state, m, ca, cb), as single-step combinational functions.
- Sub-module acorn_step_dw: combinational DW-step chain with inputs state, m vector, ca vector, cb, decrypt. Outputs are next state and the keystream/xor vector. It is reused by both the DATA and PAD phases.

Test Plan:
- Encrypt, DW=8, len_beats=16 (128-bit plaintext 0x000102...0F):
  - out_data must match the C golden model bit-for-bit.
  - state_out must match the golden model after padding; done must fire exactly 16+32+1 cycles after start under full throughput.
- Round trip: decrypt of the ciphertext above with the same state_in -> plaintext recovered, and state_out identical to the encrypt run.
- len_beats=0, DW=8 -> in_ready never asserts; done 33 cycles after start; state_out equals the golden model for padding only.
- Back-pressure: out_ready=0 for 5 cycles mid-message -> in_ready=0, out_data stable, no beat lost; state_out unchanged versus the no-stall run.
- Width equivalence: DW=1 (128 beats) vs DW=32 (4 beats) with the same message -> identical ciphertext bits and state_out.
- Reset asserted in DATA at beat 7 -> busy=0, out_valid=0, state_out=0 next cycle. A new start then completes correctly. start pulsed while busy -> no effect.
